// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, decode handshake and redirect.
// The master side belongs to the fetch stage; the slave side is memory, decode and branch resolution.
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc,
        output if_pc_plus4,
        input  redirect,
        input  redirect_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc,
        input  if_pc_plus4,
        output redirect,
        output redirect_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// MIPS instruction fetch stage: holds the PC, issues one memory fetch at a time and presents the
// fetched word to decode; a redirect reloads the PC and discards any obsolete fetch.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           clk,
    input logic           rst_n,
    instr_fetch_if.master bus
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

    localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] pc4_q, pc4_d;

    logic [31:0] redirect_aligned;
    logic [31:0] pc_inc;

    assign redirect_aligned = {bus.redirect_pc[31:2], 2'b00};
    assign pc_inc           = pc_q + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= ResetPcAligned;
            drop_q  <= 1'b0;
            instr_q <= 32'h0;
            if_pc_q <= 32'h0;
            pc4_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            instr_q <= instr_d;
            if_pc_q <= if_pc_d;
            pc4_q   <= pc4_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        instr_d = instr_q;
        if_pc_d = if_pc_q;
        pc4_d   = pc4_q;

        unique case (state_q)
            StIdle: state_d = StReq;

            StReq: begin
                // An ungranted address may still move; a granted one becomes a fetch to discard.
                if (bus.redirect) pc_d = redirect_aligned;
                if (bus.imem_gnt) begin
                    state_d = StWait;
                    drop_d  = bus.redirect;
                end
            end

            StWait: begin
                if (bus.imem_rvalid) begin
                    if (!drop_q && !bus.redirect) begin
                        instr_d = bus.imem_rdata;
                        if_pc_d = pc_q;
                        pc4_d   = pc_inc;
                        pc_d    = pc_inc;
                        state_d = StHold;
                    end else begin
                        drop_d  = 1'b0;
                        state_d = StReq;
                        if (bus.redirect) pc_d = redirect_aligned;
                    end
                end else if (bus.redirect) begin
                    pc_d   = redirect_aligned;
                    drop_d = 1'b1;
                end
            end

            StHold: begin
                if (bus.redirect) begin
                    pc_d    = redirect_aligned;
                    state_d = StReq;
                end else if (bus.if_ready) begin
                    state_d = StReq;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    assign bus.imem_req    = (state_q == StReq);
    assign bus.imem_addr   = pc_q;
    assign bus.if_valid    = (state_q == StHold);
    assign bus.if_instr    = instr_q;
    assign bus.if_pc       = if_pc_q;
    assign bus.if_pc_plus4 = pc4_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: transaction-level model of fetch order, flushes and decode handshake,
// plus directed scenarios with literal expectations; a second instance exercises PC wrap-around.
module tb_instr_fetch;

    localparam logic [31:0] RPC     = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_if bus ();
    instr_fetch_if wbus ();

    instr_fetch #(.RESET_PC(RPC))     u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    instr_fetch #(.RESET_PC(WRAP_PC)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(wbus));

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_000C) return 32'h8C22_0004;
        if (a == 32'h0000_0010) return 32'h1022_0003;
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic nstep();
        @(negedge clk);
        #1;
    endtask

    // Memory responder: grants when idle, answers rsp_lat cycles after the grant cycle.
    bit          gnt_en = 1'b1;
    bit          rsp_stall = 1'b0;
    int          rsp_lat = 0;
    bit          pend = 1'b0;
    bit          gnt_prev = 1'b0;
    int          cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    logic [31:0] addr_prev = 32'h0;

    initial begin
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.imem_rvalid = 1'b0;
            if (gnt_prev) begin
                pend      = 1'b1;
                pend_addr = addr_prev;
                cnt       = rsp_lat;
            end
            if (pend && !rsp_stall) begin
                if (cnt == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem_word(pend_addr);
                    pend            = 1'b0;
                end else begin
                    cnt--;
                end
            end
            bus.imem_gnt = bus.imem_req && gnt_en && !pend;
            gnt_prev     = bus.imem_gnt;
            addr_prev    = bus.imem_addr;
        end
    end

    // Zero-wait memory and always-ready decode for the wrap-around instance.
    bit          wgp = 1'b0;
    logic [31:0] wap = 32'h0;
    logic [31:0] wrq[$];
    logic [31:0] wpq[$];
    logic [31:0] wp4q[$];

    initial begin
        wbus.imem_gnt    = 1'b0;
        wbus.imem_rvalid = 1'b0;
        wbus.imem_rdata  = 32'h0;
        wbus.if_ready    = 1'b1;
        wbus.redirect    = 1'b0;
        wbus.redirect_pc = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            wbus.imem_rvalid = wgp;
            wbus.imem_rdata  = mem_word(wap);
            wbus.imem_gnt    = wbus.imem_req;
            wgp              = wbus.imem_gnt;
            wap              = wbus.imem_addr;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            wrq.delete();
            wpq.delete();
            wp4q.delete();
        end else begin
            if (wbus.imem_req && wbus.imem_gnt) wrq.push_back(wbus.imem_addr);
            if (wbus.if_valid && wbus.if_ready) begin
                wpq.push_back(wbus.if_pc);
                wp4q.push_back(wbus.if_pc_plus4);
            end
        end
    end

    // Reference model: which address must be requested next, whether an outstanding fetch is
    // stale, and when an instruction must be on offer to decode.
    logic [31:0] want = RPC;
    logic [31:0] grant_addr = 32'h0;
    logic [31:0] deliver_addr = 32'h0;
    logic [31:0] prev_instr = 32'h0;
    logic [31:0] prev_pc = 32'h0;
    bit          outst = 1'b0;
    bit          flushed = 1'b0;
    bit          exp_valid = 1'b0;
    bit          hold_prev = 1'b0;
    int          cyc = 0;
    int          xfer_cnt = 0;
    logic [31:0] xfer_q[$];
    logic [31:0] req_q[$];
    int          xfer_t[$];

    always @(negedge clk) begin
        bit redir;
        bit tr;
        bit nxt_valid;
        cyc++;
        if (!rst_n) begin
            chk1("rst_imem_req", bus.imem_req, 1'b0);
            chk1("rst_if_valid", bus.if_valid, 1'b0);
            chk("rst_imem_addr", bus.imem_addr, RPC);
            chk("rst_if_instr", bus.if_instr, 32'h0);
            chk("rst_if_pc", bus.if_pc, 32'h0);
            chk("rst_if_pc_plus4", bus.if_pc_plus4, 32'h0);
            want      = RPC;
            outst     = 1'b0;
            flushed   = 1'b0;
            exp_valid = 1'b0;
            hold_prev = 1'b0;
        end else begin
            redir = bus.redirect;
            tr    = bus.if_valid && bus.if_ready;
            chk1("if_valid", bus.if_valid, exp_valid);
            if (bus.imem_req) begin
                chk("imem_addr", bus.imem_addr, want);
                chk1("single_outstanding", outst, 1'b0);
            end
            if (bus.if_valid) begin
                chk("if_instr", bus.if_instr, mem_word(bus.if_pc));
                chk("if_pc", bus.if_pc, deliver_addr);
                chk("if_pc_plus4", bus.if_pc_plus4, bus.if_pc + 32'd4);
                if (hold_prev) begin
                    chk("hold_instr", bus.if_instr, prev_instr);
                    chk("hold_pc", bus.if_pc, prev_pc);
                end
            end
            hold_prev  = bus.if_valid && !bus.if_ready && !redir;
            prev_instr = bus.if_instr;
            prev_pc    = bus.if_pc;
            nxt_valid  = exp_valid && !bus.if_ready && !redir;
            if (tr) begin
                xfer_cnt++;
                xfer_q.push_back(bus.if_pc);
                xfer_t.push_back(cyc);
            end
            if (outst && bus.imem_rvalid) begin
                outst = 1'b0;
                if (!flushed && !redir) begin
                    nxt_valid    = 1'b1;
                    deliver_addr = grant_addr;
                    want         = grant_addr + 32'd4;
                end
            end else if (outst && redir) begin
                flushed = 1'b1;
            end
            if (bus.imem_req && bus.imem_gnt) begin
                outst      = 1'b1;
                grant_addr = bus.imem_addr;
                flushed    = redir;
                req_q.push_back(bus.imem_addr);
            end
            if (redir) want = {bus.redirect_pc[31:2], 2'b00};
            exp_valid = nxt_valid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        bit seen_beq;
        bus.if_ready    = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        repeat (3) @(posedge clk);

        // Sequential fetch from reset with zero-wait memory.
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk1("first_req_cycle1", bus.imem_req, 1'b0);
        @(negedge clk);
        chk1("first_req_cycle2", bus.imem_req, 1'b1);
        chk("first_req_addr", bus.imem_addr, 32'h0);
        for (int i = 0; i < 40 && xfer_cnt < 3; i++) nstep();
        chk("seq_xfer_count", xfer_cnt, 3);
        chk("seq_pc0", xfer_q[0], 32'h0);
        chk("seq_pc1", xfer_q[1], 32'h4);
        chk("seq_pc2", xfer_q[2], 32'h8);
        chk("seq_req1", req_q[1], 32'h4);
        chk("seq_req2", req_q[2], 32'h8);
        chk("seq_throughput", xfer_t[2] - xfer_t[1], 3);

        // Decode stall on the lw at 0xC.
        @(posedge clk);
        #1 bus.if_ready = 1'b0;
        for (int i = 0; i < 20 && !bus.if_valid; i++) nstep();
        chk1("stall_valid_seen", bus.if_valid, 1'b1);
        rsp_lat = 2;
        n0 = xfer_cnt;
        for (int i = 0; i < 5; i++) begin
            chk("stall_instr", bus.if_instr, 32'h8C22_0004);
            chk("stall_pc", bus.if_pc, 32'h0000_000C);
            chk1("stall_no_req", bus.imem_req, 1'b0);
            nstep();
        end
        @(posedge clk);
        #1 bus.if_ready = 1'b1;
        @(posedge clk);
        #1 bus.if_ready = 1'b0;
        nstep();
        chk("stall_single_xfer", xfer_cnt, n0 + 1);
        chk("stall_xfer_pc", xfer_q[xfer_q.size() - 1], 32'h0000_000C);

        // Redirect while the fetch at 0x10 is in flight.
        for (int i = 0; i < 20 && !(bus.imem_req && bus.imem_gnt); i++) nstep();
        chk("wait_grant_addr", bus.imem_addr, 32'h0000_0010);
        @(posedge clk);
        #1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0040;
        @(posedge clk);
        #1 bus.redirect = 1'b0;
        rsp_lat  = 0;
        seen_beq = 1'b0;
        for (int i = 0; i < 20 && !bus.imem_req; i++) begin
            if (bus.if_valid && bus.if_instr == 32'h1022_0003) seen_beq = 1'b1;
            nstep();
        end
        chk1("flush_never_presented", seen_beq, 1'b0);
        chk1("flush_req_seen", bus.imem_req, 1'b1);
        chk("flush_next_addr", bus.imem_addr, 32'h0000_0040);

        // Redirect together with if_ready in HOLD; target low bits dropped.
        for (int i = 0; i < 20 && !bus.if_valid; i++) nstep();
        chk("hold_redirect_pc", bus.if_pc, 32'h0000_0040);
        n0 = xfer_cnt;
        @(posedge clk);
        #1;
        bus.if_ready    = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        @(posedge clk);
        #1;
        bus.redirect = 1'b0;
        for (int i = 0; i < 20 && !(bus.imem_req && bus.imem_gnt); i++) nstep();
        chk("redir_xfer_once", xfer_cnt, n0 + 1);
        chk("redir_xfer_pc", xfer_q[xfer_q.size() - 1], 32'h0000_0040);
        chk("redir_aligned_addr", bus.imem_addr, 32'h0000_0100);

        // Asynchronous reset while the 0x100 fetch is outstanding, stale data after release.
        rsp_stall = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk1("async_rst_req", bus.imem_req, 1'b0);
        chk1("async_rst_valid", bus.if_valid, 1'b0);
        chk("async_rst_addr", bus.imem_addr, RPC);
        chk("async_rst_pc", bus.if_pc, 32'h0);
        repeat (2) @(posedge clk);
        #3;
        rst_n     = 1'b1;
        rsp_stall = 1'b0;
        n0 = xfer_cnt;
        for (int i = 0; i < 20 && xfer_cnt == n0; i++) nstep();
        chk("post_rst_xfer_count", xfer_cnt, n0 + 1);
        chk("post_rst_xfer_pc", xfer_q[xfer_q.size() - 1], RPC);

        // Wrap-around instance has run since the last release.
        repeat (12) nstep();
        chk("wrap_req0", wrq[0], 32'hFFFF_FFFC);
        chk("wrap_pc0", wpq[0], 32'hFFFF_FFFC);
        chk("wrap_plus4", wp4q[0], 32'h0000_0000);
        chk("wrap_req1", wrq[1], 32'h0000_0000);
        chk("wrap_pc1", wpq[1], 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the MIPS datapath. Holds the program counter and fetches one 32-bit instruction at a time from instruction memory over a request/grant/response interface. Presents each instruction to the decode stage (the control unit consumes bits [31:26] and [5:0]) through a valid/ready handshake. Accepts a PC redirect, the branch/jump target resolved downstream from the Branch/Jump control outputs, and discards any fetch made obsolete by it.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address; bits [1:0] are always 0.
- `imem_gnt`  in  1  memory accepted the request this cycle.
- `imem_rvalid`  in  1  fetch data valid this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `if_valid`  out  1  instruction available to decode.
- `if_ready`  in  1  decode accepts the instruction this cycle.
- `if_instr`  out  32  instruction word.
- `if_pc`  out  32  address of `if_instr`.
- `if_pc_plus4`  out  32  `if_pc` + 4.
- `redirect`  in  1  load a new PC and flush the in-flight fetch.
- `redirect_pc`  in  32  new PC; bits [1:0] are ignored and forced to 00.

## Operation
- State machine IDLE, REQ, WAIT, HOLD, plus a 1-bit `drop` flag and a 32-bit `pc` register.
- Reset: state=IDLE, pc=RESET_PC, drop=0. Outputs: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0.
- IDLE: always goes to REQ on the next edge.
- REQ: imem_req=1, imem_addr=pc.
  - imem_gnt=1: go to WAIT.
  - redirect=1 with imem_gnt=0: pc←redirect_pc and stay in REQ. The address may change because it has not been granted.
  - redirect=1 with imem_gnt=1: pc←redirect_pc, drop←1, go to WAIT.
- WAIT: imem_req=0.
  - imem_rvalid=1 with drop=0 and no redirect: capture if_instr←imem_rdata, if_pc←pc, if_pc_plus4←pc+4, pc←pc+4, if_valid←1, go to HOLD.
  - imem_rvalid=1 with drop=1 or redirect=1: discard the data, clear drop, and go to REQ. A same-cycle redirect also sets pc←redirect_pc.
  - redirect=1 with no rvalid: pc←redirect_pc, drop←1, stay in WAIT. Repeated redirects update pc each time; the last one wins.
- HOLD: if_valid=1. Outputs are stable until the handshake completes.
  - if_ready=1: handshake completes, if_valid←0, go to REQ.
  - redirect=1: if_valid←0, pc←redirect_pc, go to REQ. If if_ready is also 1, the instruction still counts as transferred.
- imem_rvalid outside WAIT is ignored. imem_gnt outside REQ is ignored.
- At most one outstanding memory request at any time.
- Arithmetic is 32-bit and unsigned. PC+4 wraps modulo 2^32 (32'hFFFF_FFFC → 32'h0000_0000).
- Asserting rst_n low mid-operation returns all registers to their reset values immediately. An outstanding response that arrives after reset release lands in REQ/IDLE and is ignored.

## Timing
- All outputs come from registers or decode the state register only. There is no combinational path from any input to any output.
- Best case (gnt in the request cycle, rvalid one cycle later):
  - Cycle N: req/gnt.
  - Cycle N+1: rvalid.
  - Cycle N+2: if_valid=1.
  - Cycle N+3: next imem_req, provided if_ready=1 in N+2.
- Sustained throughput is one instruction per 3 cycles with zero-wait memory.
- First imem_req is asserted in the second cycle after rst_n deasserts (IDLE → REQ).
- Redirect takes effect on the next edge. The first request to redirect_pc appears no later than the cycle after the flushed response returns.

## Test plan
- Reset/sequential fetch, RESET_PC=0, zero-wait memory, if_ready=1 → requests at 0x0, 0x4, 0x8 and if_pc sequence 0x0, 0x4, 0x8; if_pc_plus4 = if_pc+4 every time.
- Decode stall: if_ready=0 for 5 cycles with if_instr=32'h8C22_0004 (lw) → if_valid, if_instr and if_pc hold unchanged and imem_req stays 0; a single transfer occurs when if_ready rises.
- Redirect in WAIT: grant at pc 0x10, redirect_pc=0x40 before rvalid, rdata=32'h1022_0003 → data never presented; next request at addr 0x40.
- Redirect with if_ready in HOLD, redirect_pc=0x103 → transfer counted once; next imem_addr=0x100 (low bits forced to 00).
- Wrap-around: RESET_PC=32'hFFFF_FFFC → if_pc_plus4=0; next request at 0x0.
- Asynchronous reset mid-WAIT, followed by a late rvalid after release → outputs at reset values immediately; the late data is ignored; first fetch at RESET_PC.
